// File: rtl/expr_eval.sv
// expr_eval: evaluates the ASCII stream  digit ((+|*) digit)*  with
// '*' binding tighter than '+'. Operands are single decimal digits.
// The outputs show the value of the longest well-formed prefix that
// ends in a digit, and flag whether the whole accepted stream is a
// complete expression or has hit a syntax error.
//
// State table:
//   S_IDLE | waiting for the first digit
//   S_NUM  | last accepted char was a digit (expression complete)
//   S_ADD  | last accepted char was '+'
//   S_MUL  | last accepted char was '*'
//   S_ERR  | syntax error seen; absorbing until clr
//
// Ports:
//   clk      in   system clock, rising edge
//   clr      in   synchronous active-low reset
//   in       in   8-bit ASCII character
//   in_valid in   character strobe
//   result   out  value of the last well-formed prefix ending in a digit
//   valid    out  accepted stream is a complete expression
//   err      out  sticky syntax error
//   ovf      out  sticky arithmetic overflow (only with EXPR_OVF_EN)
//
// Build option: define EXPR_OVF_EN to add the ovf output.

module expr_eval #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             err
`ifdef EXPR_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NUM  = 3'd1,
        S_ADD  = 3'd2,
        S_MUL  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             is_dig, is_add, is_mul;
    logic [3:0]       digit;
    logic [WIDTH-1:0] digit_ext;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] acc;

    assign digit     = in[3:0];
    assign digit_ext = {{(WIDTH-4){1'b0}}, digit};

`ifdef EXPR_OVF_EN
    logic       ovf_q, ovf_d;
    logic [3:0] prod_hi;
    logic       acc_c;
    logic       res_c;

    // Full-width product and sum so the carry-out can be observed.
    always_comb begin
        {prod_hi, prod} = {4'b0, term_q} * {{WIDTH{1'b0}}, digit};
        {acc_c, acc}    = {1'b0, sum_q} + {1'b0, term_q};
    end
`else
    always_comb begin
        prod = term_q * digit_ext;
        acc  = sum_q + term_q;
    end
`endif

    always_comb begin
        is_dig = (in >= 8'h30) && (in <= 8'h39);
        is_add = (in == 8'h2B);
        is_mul = (in == 8'h2A);
    end

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        term_d   = term_q;
        result_d = result_q;
        valid_d  = valid_q;
        err_d    = err_q;
`ifdef EXPR_OVF_EN
        ovf_d    = ovf_q;
        res_c    = 1'b0;
`endif
        if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (is_dig) begin
                        state_d = S_NUM;
                        sum_d   = '0;
                        term_d  = digit_ext;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_add)      state_d = S_ADD;
                    else if (is_mul) state_d = S_MUL;
                    else             state_d = S_ERR;
                end
                S_ADD: begin
                    if (is_dig) begin
                        state_d = S_NUM;
                        sum_d   = acc;
                        term_d  = digit_ext;
`ifdef EXPR_OVF_EN
                        if (acc_c) ovf_d = 1'b1;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_MUL: begin
                    if (is_dig) begin
                        state_d = S_NUM;
                        term_d  = prod;
`ifdef EXPR_OVF_EN
                        if (prod_hi != 4'd0) ovf_d = 1'b1;
`endif
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_ERR;
            endcase

            valid_d = (state_d == S_NUM);
            err_d   = (state_d == S_ERR);

            // result only moves when the stream ends in a digit; after an
            // operator or an error it keeps the last good value.
            if (state_d == S_NUM) begin
`ifdef EXPR_OVF_EN
                {res_c, result_d} = {1'b0, sum_d} + {1'b0, term_d};
                if (res_c) ovf_d = 1'b1;
`else
                result_d = sum_d + term_d;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            term_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef EXPR_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            term_q   <= term_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
`ifdef EXPR_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign result = result_q;
    assign valid  = valid_q;
    assign err    = err_q;
`ifdef EXPR_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_expr_eval.sv
// Testbench for expr_eval: directed streams with literal expectations,
// then a long randomized stream checked every cycle against a model that
// keeps the accepted text and re-evaluates it from scratch.

module tb_expr_eval;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         clr;
    logic [7:0]   in;
    logic         in_valid;
    logic [W-1:0] result;
    logic         valid;
    logic         err;
`ifdef EXPR_OVF_EN
    logic         ovf;
`endif

    expr_eval #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .in       (in),
        .in_valid (in_valid),
        .result   (result),
        .valid    (valid),
        .err      (err)
`ifdef EXPR_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    int   tests  = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    // Model: accepted characters of the current expression.
    logic [7:0] s[$];
    logic       m_err    = 1'b0;
    logic       m_valid  = 1'b0;
    int         m_result = 0;
`ifdef EXPR_OVF_EN
    logic       m_ovf    = 1'b0;
`endif

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    // Sum of products over the accepted text; one result modulo 2^W and
    // one exact value (capped, only its size relative to 2^W matters).
    task automatic eval_expr(output int v_mod, output longint v_true);
        int     tot_m, prd_m, dv;
        longint tot_t, prd_t;
        tot_m = 0;
        tot_t = 0;
        prd_m = int'(s[0]) - 48;
        prd_t = prd_m;
        for (int i = 1; i + 1 < s.size(); i += 2) begin
            dv = int'(s[i+1]) - 48;
            if (s[i] == 8'h2A) begin
                prd_m = (prd_m * dv) & MASK;
                prd_t = prd_t * dv;
            end else begin
                tot_m = (tot_m + prd_m) & MASK;
                tot_t = tot_t + prd_t;
                prd_m = dv;
                prd_t = dv;
            end
            if (prd_t > 1000000) prd_t = 1000000;
            if (tot_t > 1000000) tot_t = 1000000;
        end
        v_mod  = (tot_m + prd_m) & MASK;
        v_true = tot_t + prd_t;
    endtask

    task automatic model_update(input logic c, input logic [7:0] ch, input logic v);
        bit     want_digit;
        bit     ok;
        int     vm;
        longint vt;
        if (!c) begin
            s.delete();
            m_err    = 1'b0;
            m_valid  = 1'b0;
            m_result = 0;
`ifdef EXPR_OVF_EN
            m_ovf    = 1'b0;
`endif
        end else if (v && !m_err) begin
            want_digit = (s.size() % 2 == 0);
            ok = want_digit ? is_digit(ch) : (ch == 8'h2B || ch == 8'h2A);
            if (ok) begin
                s.push_back(ch);
                if (is_digit(ch)) begin
                    eval_expr(vm, vt);
                    m_result = vm;
                    m_valid  = 1'b1;
`ifdef EXPR_OVF_EN
                    if (vt > MASK) m_ovf = 1'b1;
`endif
                end else begin
                    m_valid = 1'b0;
                end
            end else begin
                m_err   = 1'b1;
                m_valid = 1'b0;
            end
        end
    endtask

    // Drive one cycle; the model consumes exactly what the DUT sampled.
    task automatic step(input logic c, input logic [7:0] ch, input logic v);
        clr      = c;
        in       = ch;
        in_valid = v;
        @(posedge clk);
        model_update(c, ch, v);
        #1;
    endtask

    task automatic send(input string str);
        for (int i = 0; i < str.len(); i++) step(1'b1, str[i], 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_result", int'(result), m_result & MASK);
            chk("cyc_valid",  int'(valid),  int'(m_valid));
            chk("cyc_err",    int'(err),    int'(m_err));
`ifdef EXPR_OVF_EN
            chk("cyc_ovf",    int'(ovf),    int'(m_ovf));
`endif
        end
    end

    initial begin
        clr      = 1'b0;
        in       = 8'h00;
        in_valid = 1'b0;
        do_reset();
        do_reset();
        chk_en = 1'b1;
        chk("reset_result", int'(result), 0);
        chk("reset_valid",  int'(valid),  0);
        chk("reset_err",    int'(err),    0);

        send("1+");
        chk("1+_valid",  int'(valid),  0);
        chk("1+_result", int'(result), 1);
        send("2*3");
        chk("123_result", int'(result), 7);
        chk("123_valid",  int'(valid),  1);
        chk("123_err",    int'(err),    0);

        do_reset();
        send("2");   chk("2345_r1", int'(result), 2);
        send("*3");  chk("2345_r2", int'(result), 6);
        send("*4");  chk("2345_r3", int'(result), 24);
        send("+5");  chk("2345_r4", int'(result), 29);
        chk("2345_valid", int'(valid), 1);

        do_reset();
        send("1+");
        send("+");
        chk("1++_err",    int'(err),    1);
        chk("1++_valid",  int'(valid),  0);
        chk("1++_result", int'(result), 1);
        send("2");
        chk("1++2_err",    int'(err),    1);
        chk("1++2_result", int'(result), 1);

        do_reset();
        send("9*9*9");
        chk("999_result", int'(result), 217);
        chk("999_valid",  int'(valid),  1);
`ifdef EXPR_OVF_EN
        chk("999_ovf",    int'(ovf),    1);
`endif

        // Idle gaps, then a reset carrying a strobed digit (reset wins).
        do_reset();
        send("3");
        step(1'b1, 8'h35, 1'b0);
        step(1'b1, 8'h35, 1'b0);
        chk("gap_result", int'(result), 3);
        send("*");
        step(1'b1, 8'h2B, 1'b0);
        step(1'b1, 8'h2B, 1'b0);
        chk("gap_valid", int'(valid), 0);
        step(1'b0, 8'h35, 1'b1);
        send("4");
        chk("gap4_result", int'(result), 4);
        chk("gap4_valid",  int'(valid),  1);
        chk("gap4_err",    int'(err),    0);

        do_reset();
        send("a");
        chk("a_err", int'(err), 1);
        do_reset();
        send("7");
        send("8");
        chk("78_err",    int'(err),    1);
        chk("78_result", int'(result), 7);
        chk("78_valid",  int'(valid),  0);

        // Random stream, mostly well-formed, with stray/wrong-class chars.
        for (int n = 0; n < 4000; n++) begin
            int         r, r2;
            logic       c, v, want_digit, dig;
            logic [7:0] ch;
            r  = $urandom_range(0, 99);
            r2 = $urandom_range(0, 99);
            c  = !((r < 2) || (m_err && r < 25));
            v  = ($urandom_range(0, 3) != 0);
            want_digit = (s.size() % 2 == 0);
            if (r2 < 3) begin
                ch = 8'($urandom_range(0, 255));
            end else begin
                dig = (r2 < 8) ? !want_digit : want_digit;
                if (dig) ch = 8'h30 + 8'($urandom_range(0, 9));
                else     ch = ($urandom_range(0, 1) != 0) ? 8'h2A : 8'h2B;
            end
            step(c, ch, v);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
